// File: rtl/pri_codec_pkg.sv
// rtl/pri_codec_pkg.sv - shared state encoding and default widths for the priority codec pair
package pri_codec_pkg;

  localparam int PRI_N = 8;
  localparam int PRI_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } pri_state_e;

endpackage

// File: rtl/pri_decoder_strobe.sv
// rtl/pri_decoder_strobe.sv - replays an accepted channel index as a timed one-hot strobe
module pri_decoder_strobe
  import pri_codec_pkg::*;
#(
  parameter int N         = PRI_N,
  parameter int W         = PRI_W,
  parameter int PULSE_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  output logic [N-1:0] out_onehot,
  output logic         out_active,
  output logic         done,
  output logic         err
);

  localparam logic [W:0] LP_N        = (W+1)'(N);
  localparam logic [7:0] LP_CNT_INIT = 8'(PULSE_LEN - 1);

  pri_state_e     r_state;
  logic [7:0]     r_cnt;
  logic [N-1:0]   r_onehot;
  logic           r_active;
  logic           r_done;
  logic           r_err;

  logic           w_ready;
  logic           w_xfer;
  logic           w_in_range;
  logic [N-1:0]   w_decoded;

  assign w_ready    = (r_state == ST_IDLE);
  assign w_xfer     = in_valid && w_ready;
  assign w_in_range = ({1'b0, in_code} < LP_N);
  assign w_decoded  = {{(N-1){1'b0}}, 1'b1} << in_code;

  // done/err are single-cycle pulses: cleared every edge unless re-armed below
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_onehot <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_in_range) begin
              r_onehot <= w_decoded;
              r_active <= 1'b1;
              r_cnt    <= LP_CNT_INIT;
              r_state  <= ST_PULSE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_PULSE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_onehot <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign out_onehot = r_onehot;
  assign out_active = r_active;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_pri_decoder_strobe.sv
// tb/tb_pri_decoder_strobe.sv - randomized and directed bench for pri_decoder_strobe
module tb_pri_decoder_strobe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       valid_a [3];
  logic [2:0] code_a  [3];
  logic       rst_a   [3];

  logic       rdy0, act0, done0, err0;
  logic [7:0] oh0;
  logic       rdy1, act1, done1, err1;
  logic [5:0] oh1;
  logic       rdy2, act2, done2, err2;
  logic [7:0] oh2;

  pri_decoder_strobe #(.N(8), .W(3), .PULSE_LEN(4)) u_dec8 (
    .clk(clk), .rst(rst_a[0]), .in_valid(valid_a[0]), .in_ready(rdy0), .in_code(code_a[0]),
    .out_onehot(oh0), .out_active(act0), .done(done0), .err(err0)
  );
  pri_decoder_strobe #(.N(6), .W(3), .PULSE_LEN(4)) u_dec6 (
    .clk(clk), .rst(rst_a[1]), .in_valid(valid_a[1]), .in_ready(rdy1), .in_code(code_a[1]),
    .out_onehot(oh1), .out_active(act1), .done(done1), .err(err1)
  );
  pri_decoder_strobe #(.N(8), .W(3), .PULSE_LEN(1)) u_dec8_p1 (
    .clk(clk), .rst(rst_a[2]), .in_valid(valid_a[2]), .in_ready(rdy2), .in_code(code_a[2]),
    .out_onehot(oh2), .out_active(act2), .done(done2), .err(err2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Timeline model: each instance remembers when its last strobe started and
  // derives every output from distances to that edge.
  int  n_of [3] = '{8, 6, 8};
  int  l_of [3] = '{4, 4, 1};
  int  t_a  [3];
  int  s_a  [3];
  int  cd_a [3];
  int  e_a  [3];
  bit  have_a [3];
  bit  last_xfer;
  logic [11:0] exp_stat;

  function automatic logic [11:0] stat(input int i);
    case (i)
      0:       return {rdy0, err0, done0, act0, oh0};
      1:       return {rdy1, err1, done1, act1, 2'b00, oh1};
      default: return {rdy2, err2, done2, act2, oh2};
    endcase
  endfunction

  function automatic logic [2:0] pri_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int b = 0; b < 8; b++) if (v[b]) idx = b[2:0];
    return idx;
  endfunction

  task automatic advance(input int i, input logic v, input logic [2:0] code, input logic r);
    int l, n;
    bit rdy, e_done, e_err, e_rdy;
    logic [7:0] e_oh;
    l = l_of[i];
    n = n_of[i];
    rdy = !have_a[i] || (t_a[i] >= s_a[i] + l + 1);
    last_xfer = v && rdy && !r;
    valid_a[i] = v;
    code_a[i]  = code;
    rst_a[i]   = r;
    @(posedge clk);
    t_a[i]++;
    if (r) begin
      have_a[i] = 1'b0;
      e_a[i]    = -1000;
    end else if (last_xfer) begin
      if (int'(code) < n) begin
        have_a[i] = 1'b1;
        s_a[i]    = t_a[i];
        cd_a[i]   = int'(code);
      end else begin
        e_a[i] = t_a[i];
      end
    end
    @(negedge clk);
    e_oh   = (have_a[i] && t_a[i] >= s_a[i] && t_a[i] < s_a[i] + l) ? (8'd1 << cd_a[i]) : 8'd0;
    e_done = have_a[i] && (t_a[i] == s_a[i] + l);
    e_err  = (t_a[i] == e_a[i]);
    e_rdy  = !have_a[i] || (t_a[i] >= s_a[i] + l + 1);
    exp_stat = {e_rdy, e_err, e_done, |e_oh, e_oh};
  endtask

  task automatic test_reset();
    advance(0, 1'b0, 3'd0, 1'b1);
    advance(0, 1'b0, 3'd0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      advance(0, 1'b0, 3'd0, 1'b0);
      tests_run++;
      if (stat(0) !== 12'b1_0_0_0_00000000) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", j, stat(0), 12'b1_0_0_0_00000000);
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] want;
    advance(0, 1'b0, 3'd0, 1'b1);
    advance(0, 1'b1, 3'd5, 1'b0);
    for (int j = 0; j < 7; j++) begin
      want = {(j >= 5) ? 1'b1 : 1'b0, 1'b0, (j == 4) ? 1'b1 : 1'b0,
              (j < 4) ? 1'b1 : 1'b0, (j < 4) ? 8'b0010_0000 : 8'h00};
      tests_run++;
      if (stat(0) !== want) begin
        tests_failed++;
        $display("FAIL single_code5 rel=%0d got=%b exp=%b", j, stat(0), want);
      end
      advance(0, 1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc0, acc7;
    int n01, n80;
    logic [2:0] cur;
    acc0 = 0; acc7 = 0; n01 = 0; n80 = 0;
    advance(0, 1'b0, 3'd0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      cur = acc0 ? 3'd7 : 3'd0;
      advance(0, !acc7, cur, 1'b0);
      if (last_xfer && cur == 3'd0) acc0 = 1;
      else if (last_xfer) acc7 = 1;
      if (oh0 == 8'h01) n01++;
      if (oh0 == 8'h80) n80++;
      tests_run++;
      if (stat(0) !== exp_stat) begin
        tests_failed++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", j, stat(0), exp_stat);
      end
    end
    tests_run++;
    if (n01 != 4 || n80 != 4) begin
      tests_failed++;
      $display("FAIL b2b_counts got=%0d/%0d exp=4/4", n01, n80);
    end
  endtask

  task automatic test_out_of_range();
    advance(1, 1'b0, 3'd0, 1'b1);
    advance(1, 1'b1, 3'd6, 1'b0);
    tests_run++;
    if (stat(1) !== 12'b1_1_0_0_00000000) begin
      tests_failed++;
      $display("FAIL oor_err got=%b exp=%b", stat(1), 12'b1_1_0_0_00000000);
    end
    advance(1, 1'b1, 3'd2, 1'b0);
    tests_run++;
    if (stat(1) !== 12'b0_0_0_1_00000100) begin
      tests_failed++;
      $display("FAIL oor_follow got=%b exp=%b", stat(1), 12'b0_0_0_1_00000100);
    end
    for (int j = 0; j < 6; j++) begin
      advance(1, 1'b0, 3'd0, 1'b0);
      tests_run++;
      if (stat(1) !== exp_stat) begin
        tests_failed++;
        $display("FAIL oor_tail cyc=%0d got=%b exp=%b", j, stat(1), exp_stat);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    advance(0, 1'b0, 3'd0, 1'b1);
    advance(0, 1'b1, 3'd4, 1'b0);
    advance(0, 1'b0, 3'd0, 1'b0);
    tests_run++;
    if (oh0 !== 8'h10) begin
      tests_failed++;
      $display("FAIL midrst_pre got=%h exp=%h", oh0, 8'h10);
    end
    advance(0, 1'b0, 3'd0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      tests_run++;
      if (stat(0) !== 12'b1_0_0_0_00000000) begin
        tests_failed++;
        $display("FAIL midrst_after cyc=%0d got=%b exp=%b", j, stat(0), 12'b1_0_0_0_00000000);
      end
      advance(0, 1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic test_pulse1_sweep();
    logic [7:0] want;
    advance(2, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      want = 8'd1 << c;
      advance(2, 1'b1, 3'(c), 1'b0);
      tests_run++;
      if (oh2 !== want || pri_enc(oh2) !== 3'(c) || stat(2) !== exp_stat) begin
        tests_failed++;
        $display("FAIL p1_sweep code=%0d got=%b enc=%0d exp=%b", c, oh2, pri_enc(oh2), want);
      end
      for (int j = 0; j < 2; j++) begin
        advance(2, 1'b0, 3'd0, 1'b0);
        tests_run++;
        if (stat(2) !== exp_stat) begin
          tests_failed++;
          $display("FAIL p1_tail code=%0d cyc=%0d got=%b exp=%b", c, j, stat(2), exp_stat);
        end
      end
    end
  endtask

  task automatic test_random(input int i, input int cycles);
    logic       v, r;
    logic [2:0] code;
    advance(i, 1'b0, 3'd0, 1'b1);
    for (int j = 0; j < cycles; j++) begin
      r    = ($urandom_range(0, 49) == 0);
      v    = 1'($urandom_range(0, 1));
      code = 3'($urandom_range(0, 7));
      advance(i, v, code, r);
      tests_run++;
      if (stat(i) !== exp_stat) begin
        tests_failed++;
        $display("FAIL random inst=%0d cyc=%0d got=%b exp=%b", i, j, stat(i), exp_stat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      valid_a[i] = 1'b0;
      code_a[i]  = 3'd0;
      rst_a[i]   = 1'b1;
      t_a[i]     = 0;
      s_a[i]     = 0;
      cd_a[i]    = 0;
      e_a[i]     = -1000;
      have_a[i]  = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_pulse();
    test_pulse1_sweep();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
